// File: rtl/spi_slave_engine_pkg.sv
// Shared SPI definitions: clock-phase modes, default geometry and the
// shifter output-bit selector used by the slave engine.
package spi_pkg;

    typedef enum logic {
        CPHA0 = 1'b0,
        CPHA1 = 1'b1
    } cpha_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    // Callers zero-extend their shifter to MAX_WIDTH and pass its real width.
    function automatic logic bit_out(input logic [MAX_WIDTH-1:0] shifter,
                                     input logic                 msb_first,
                                     input int unsigned          width = DEFAULT_WIDTH);
        logic [5:0] top;
        top = 6'(width - 1);
        return msb_first ? shifter[top] : shifter[0];
    endfunction

endpackage

// File: rtl/spi_slave_engine.sv
// SPI slave shift engine (CPOL=0): configurable width, bit order and phase,
// in-frame word index and toggle-based word events for a downstream CDC stage.
module spi_slave_engine
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_toggle,
    output logic [CNT_W-1:0] rx_idx,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_toggle,
    output logic             frame_active
);

    localparam int unsigned      BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam cpha_e            MODE     = cpha_e'(CPHA[0]);
    localparam logic             MSB      = (MSB_FIRST != 0);

    logic             samp_clk;
    logic             launch_clk;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_word;
    logic             word_done;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_src;
    logic             tx_live;
    logic             tx_load;

    assign samp_clk   = (MODE == CPHA1) ? ~sclk : sclk;
    assign launch_clk = ~samp_clk;
    assign miso_oe    = ~cs_n;

    assign word_done = (bit_cnt == LAST_BIT);
    assign rx_word   = MSB ? {rx_shift, mosi} : {mosi, rx_shift};

    always_ff @(posedge samp_clk or posedge cs_n) begin
        if (cs_n) begin
            bit_cnt      <= '0;
            word_cnt     <= '0;
            rx_shift     <= '0;
            frame_active <= 1'b0;
        end else if (!rst_n) begin
            bit_cnt      <= '0;
            word_cnt     <= '0;
            rx_shift     <= '0;
            frame_active <= 1'b1;
        end else begin
            frame_active <= 1'b1;
            rx_shift     <= MSB ? rx_word[WIDTH-2:0] : rx_word[WIDTH-1:1];
            bit_cnt      <= word_done ? '0 : bit_cnt + 1'b1;
            if (word_done) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // bit_cnt is held at zero while cs_n is high, so word_done already implies an open frame.
    always_ff @(posedge samp_clk) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_idx    <= '0;
            rx_toggle <= 1'b0;
        end else if (word_done) begin
            rx_data   <= rx_word;
            rx_idx    <= word_cnt;
            rx_toggle <= ~rx_toggle;
        end
    end

    // Until the first launch edge of a frame the shifter reads tx_data directly,
    // which gives the transparent parallel load while cs_n is high.
    assign tx_src  = tx_live ? tx_shift : tx_data;
    assign tx_load = (bit_cnt == '0) && (frame_active || (MODE == CPHA1));

    always_ff @(posedge launch_clk or posedge cs_n) begin
        if (cs_n) begin
            tx_live <= 1'b0;
        end else begin
            tx_live <= 1'b1;
        end
    end

    always_ff @(posedge launch_clk) begin
        if (!rst_n) begin
            tx_shift  <= '0;
            tx_toggle <= 1'b0;
        end else if (miso_oe) begin
            if (tx_load) begin
                tx_shift  <= tx_data;
                tx_toggle <= ~tx_toggle;
            end else begin
                tx_shift  <= MSB ? {tx_src[WIDTH-2:0], 1'b0} : {1'b0, tx_src[WIDTH-1:1]};
            end
        end
    end

    assign miso = cs_n ? 1'b0 : bit_out(MAX_WIDTH'(tx_src), MSB, WIDTH);

endmodule

// File: doc/spi_slave_engine.md
# spi_slave_engine

Parametrised SPI slave shift engine. It replaces the fixed 8-bit, mode-0-only receive/echo path with configurable word width, bit order and clock phase. It counts words within a chip-select frame and provides toggle-based word events so that a separate clock-domain-crossing stage can hand words to the system `clk` domain safely. All logic runs on `sclk` edges; the engine contains no system-clock logic.

## Interface
Parameters:
- `WIDTH`, default 8: bits per SPI word, minimum 2.
- `MSB_FIRST`, default 1: 1 shifts MSB first, 0 shifts LSB first (both RX and TX).
- `CPHA`, default 0: 0 samples on rising and launches on falling edge; 1 launches on rising and samples on falling edge. CPOL is fixed at 0.
- `CNT_W`, default 4: width of the in-frame word index. The index wraps modulo 2^CNT_W.

Ports:
- `sclk` in 1: SPI clock, the only clock.
- `rst_n` in 1: reset, synchronous to sclk, active-low.
- `cs_n` in 1: chip select, active-low. A high level clears the frame state asynchronously.
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out.
- `miso_oe` out 1: output enable for the pad, equal to `~cs_n`.
- `rx_data` out WIDTH: last complete received word. It is held until the next word completes.
- `rx_toggle` out 1: flips once per completed received word.
- `rx_idx` out CNT_W: in-frame index of the word currently in `rx_data`.
- `tx_data` in WIDTH: next word to transmit. Upstream must hold it quasi-static.
- `tx_toggle` out 1: flips each time `tx_data` is loaded into the TX shifter.
- `frame_active` out 1: high from the first sampling edge of a frame until `cs_n` rises.

## Operation
- **Reset** (`rst_n` low at a sampling edge):
  - `rx_data` = 0, `rx_toggle` = 0, `tx_toggle` = 0, `rx_idx` = 0.
  - Bit counter = 0, word counter = 0, TX shifter = 0.
  - Reset takes effect only on sclk edges. It has priority over all other actions at that edge.
- **cs_n high** (asynchronous clear of frame state):
  - Bit counter = 0, word counter = 0, RX shift register contents discarded.
  - `frame_active` = 0.
  - The TX shifter is parallel-loaded from `tx_data` (transparent while `cs_n` is high).
  - `miso_oe` = 0 and `miso` = 0. The pad is tri-stated by the top level using `miso_oe`.
  - `rx_data`, `rx_toggle`, `rx_idx` and `tx_toggle` retain their values.
- **Sampling edge** (rising if CPHA=0, falling if CPHA=1):
  - `mosi` is shifted into the RX register.
  - The bit counter increments and wraps at WIDTH.
  - When the bit counter reaches WIDTH-1:
    - `rx_data` takes the assembled word, including the current bit.
    - `rx_idx` takes the word counter value.
    - `rx_toggle` flips.
    - The word counter increments, wrapping at 2^CNT_W.
- **Launch edge** (falling if CPHA=0, rising if CPHA=1):
  - The TX shifter advances one bit.
  - On the launch edge that follows a word boundary, the shifter reloads from `tx_data` and `tx_toggle` flips.
  - Under CPHA=0, the first bit of word 0 is presented combinationally once `cs_n` falls, before any edge.
  - Under CPHA=1, the first rising edge presents bit 0 of word 0. That load counts as the word-0 load and flips `tx_toggle`.
- **miso**: equals the shifter's current output bit. This is bit WIDTH-1 when `MSB_FIRST`=1, bit 0 otherwise.
- **Underrun**: none is detected. The engine transmits whatever is on `tx_data` at load time.

## Timing
- RX latency: `rx_data`, `rx_idx` and `rx_toggle` update on the same sampling edge that captures the last bit of the word.
- TX load happens on the launch edge immediately after the last sampling edge of the previous word. `tx_data` must be stable at least one half sclk period earlier.
- Consumers detect words by edge-detecting `rx_toggle` after a 2-flop synchroniser. `rx_data` is stable for at least WIDTH-1 sclk periods after a toggle. Back-to-back words are legal; the consumer must sample within that window.
- Partial word (`cs_n` rises mid-word): the partial bits are discarded. No toggle occurs and `rx_data` is unchanged.
- Word-index wrap: after word 2^CNT_W - 1, `rx_idx` returns to 0 within the same frame.
- `rst_n` low together with a word-completing sampling edge: reset wins and no toggle occurs.
- `cs_n` rising with a launch edge in the same instant: the clear wins.

## Structure
- Shared package `spi_pkg`:
  - Mode encoding constants (CPHA0, CPHA1).
  - Default `WIDTH`/`CNT_W`.
  - Function `bit_out(shifter, msb_first)`.
- Natural sub-module: `spi_toggle_sync`, the 2-flop synchroniser plus edge detect used by `clk`-domain consumers. It lives outside this engine, which instantiates no sub-modules.
- Top level: muxes `miso` onto the uio pin 2 output, drives `uio_oe[2]` from `miso_oe`, and ties unused outputs to 0.

## Test plan
- Mode 0, WIDTH=8, MSB first: send 0xA5 while `tx_data`=0x3C. Required: `rx_data`=0xA5, `rx_toggle` flips once, `rx_idx`=0, MISO bits 0,0,1,1,1,1,0,0.
- Mode 0, LSB first: send 0x01. Required: `rx_data`=0x01, and MISO carries the LSB of `tx_data` first.
- CPHA=1, WIDTH=12: send 0xABC with `tx_data`=0x123. Required: `rx_data`=0xABC and MISO 0x123 MSB first, with data launched on rising edges.
- Frame of 18 words with CNT_W=4. Required: `rx_idx` runs 0..15, 0, 1, and `rx_toggle` flips 18 times.
- `cs_n` rises after 5 bits, then a new frame sends 0x5A. Required: no toggle for the partial word, `rx_data`=0x5A, `rx_idx`=0.
- `rst_n` low on the last sampling edge of a word. Required: `rx_data`=0, toggles=0, `rx_idx`=0, and the word counter is cleared.
